// File: rtl/instr_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, the canonical NOP
// and the legal immediate ranges for each immediate-carrying format.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX = 32'sd1048574;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters the immediate per format and
// flags out-of-range, misaligned or illegal-format requests.
module instr_pack
    import instr_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic signed [31:0] w_imm;

    assign w_imm = i_imm;

    // Range errors still produce a word built from the truncated immediate bits.
    always_comb begin
        o_instr = NOP_INSTR;
        o_err   = 1'b1;
        case (i_fmt)
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = 1'b0;
            end
            FMT_I: begin
                o_instr = {w_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
            end
            FMT_S: begin
                o_instr = {w_imm[11:5], i_rs2, i_rs1, i_funct3, w_imm[4:0], i_opcode};
                o_err   = (w_imm < IMM12_MIN) || (w_imm > IMM12_MAX);
            end
            FMT_B: begin
                o_instr = {w_imm[12], w_imm[10:5], i_rs2, i_rs1, i_funct3,
                           w_imm[4:1], w_imm[11], i_opcode};
                o_err   = (w_imm < IMM_B_MIN) || (w_imm > IMM_B_MAX) || w_imm[0];
            end
            FMT_U: begin
                o_instr = {w_imm[31:12], i_rd, i_opcode};
                o_err   = (w_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                o_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_rd, i_opcode};
                o_err   = (w_imm < IMM_J_MIN) || (w_imm > IMM_J_MAX) || w_imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming instruction encoder: one output register stage with valid/ready
// handshake, sequential word address and a sticky error flag.
module instruction_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic                  err_seen
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    logic                  r_valid;
    logic [31:0]           r_instr;
    logic                  r_err;
    logic                  r_err_seen;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic [31:0] w_instr;
    logic        w_err;
    logic        w_in_xfer;
    logic        w_out_xfer;

    instr_pack u_pack (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    assign in_ready   = !r_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    // Output stage: a draining word advances the address before a new word lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_instr    <= 32'd0;
            r_err      <= 1'b0;
            r_err_seen <= 1'b0;
            r_addr     <= BASE;
        end else begin
            if (w_out_xfer) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if (r_err)
                    r_err_seen <= 1'b1;
            end
            if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_instr <= w_instr;
                r_err   <= w_err;
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;
    assign err_seen  = r_err_seen;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed literal vectors, then randomized
// traffic checked every cycle against a field-level encoder model.
module tb_instruction_encoder;

    localparam int AW   = 2;
    localparam int BASE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic          err_seen;

    int n_tests = 0;
    int n_fail  = 0;

    instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_seen  (err_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder written with shifts and masks on the field values.
    function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] u);
        logic [31:0] lo;
        logic [31:0] rdp;
        lo  = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        rdp = 32'(rd) << 7;
        case (f)
            3'd0: return (32'(f7) << 25) | (32'(rs2) << 20) | lo | rdp;
            3'd1: return ((u & 32'hFFF) << 20) | lo | rdp;
            3'd2: return (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | lo | ((u & 32'h1F) << 7);
            3'd3: return (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                         (32'(rs2) << 20) | lo | (((u >> 1) & 32'hF) << 8) |
                         (((u >> 11) & 32'd1) << 7);
            3'd4: return (u & 32'hFFFF_F000) | rdp | 32'(op);
            3'd5: return (((u >> 20) & 32'd1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                         (((u >> 11) & 32'd1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                         rdp | 32'(op);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic errf(input logic [2:0] f, input logic [31:0] u);
        int s;
        s = int'(u);
        case (f)
            3'd0:    return 1'b0;
            3'd1,
            3'd2:    return (s < -2048) || (s > 2047);
            3'd3:    return (s < -4096) || (s > 4094) || ((u & 32'd1) != 0);
            3'd4:    return (u & 32'hFFF) != 0;
            3'd5:    return (s < -1048576) || (s > 1048574) || ((u & 32'd1) != 0);
            default: return 1'b1;
        endcase
    endfunction

    // Immediate generator: recovers the immediate from an encoded word.
    function automatic logic [31:0] imm_dec(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'd0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural model state
    bit          m_ok = 1'b0;
    bit          m_valid, m_err, m_seen;
    logic [31:0] m_instr, m_imm;
    logic [2:0]  m_fmt;
    int          m_addr;

    always @(posedge clk) begin
        bit oxf, ixf;
        if (rst) begin
            m_valid = 1'b0; m_err = 1'b0; m_seen = 1'b0;
            m_instr = 32'd0; m_addr = BASE; m_ok = 1'b1;
        end else if (m_ok) begin
            oxf = m_valid && out_ready;
            ixf = in_valid && (!m_valid || out_ready);
            if (oxf) begin
                m_addr = (m_addr + 1) % (1 << AW);
                if (m_err) m_seen = 1'b1;
            end
            if (ixf) begin
                m_valid = 1'b1;
                m_instr = enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                m_err   = errf(in_fmt, in_imm);
                m_fmt   = in_fmt;
                m_imm   = in_imm;
            end else if (oxf) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_addr", 32'(out_addr), 32'(m_addr));
            chk("err_seen", 32'(err_seen), 32'(m_seen));
            if (m_valid) begin
                chk("out_instr", out_instr, m_instr);
                chk("out_err", 32'(out_err), 32'(m_err));
                if (!m_err && m_fmt >= 3'd1 && m_fmt <= 3'd5)
                    chk("imm_roundtrip", imm_dec(m_fmt, out_instr), m_imm);
            end
        end
    end

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = 7'd0; in_imm = imm;
    endtask

    // Presents one bundle and returns 2 time units after the edge that took it.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] imm);
        int k;
        set_fields(f, op, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        if (k == 20) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] ins, input logic e, input int a);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_instr"}, out_instr, ins);
        chk({name, "_err"}, 32'(out_err), 32'(e));
        chk({name, "_addr"}, 32'(out_addr), 32'(a));
    endtask

    localparam logic [31:0] BND [0:18] = '{
        32'hFFFF_F7FF, 32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800,
        32'hFFFF_EFFF, 32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_0FFF, 32'h0000_1000,
        32'hFFEF_FFFF, 32'hFFF0_0000, 32'h000F_FFFE, 32'h000F_FFFF, 32'h0010_0000,
        32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd3);
        chk("rst_err_seen", 32'(err_seen), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        lit("addi", 32'h0050_0093, 1'b0, 3);
        send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        lit("sw", 32'h0020_A423, 1'b0, 0);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4);
        lit("beq", 32'hFE20_8EE3, 1'b0, 1);
        send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
        lit("jal", 32'h0080_00EF, 1'b0, 2);
        send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        lit("lui", 32'h1234_52B7, 1'b0, 3);
        chk("lui_err_seen", 32'(err_seen), 32'd0);
        send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
        lit("lui_bad", 32'h1234_52B7, 1'b1, 0);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        lit("clean_after_err", 32'h0050_0093, 1'b0, 1);
        chk("sticky_err_seen", 32'(err_seen), 32'd1);
        send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        lit("addi_2048", 32'h8000_0093, 1'b1, 2);
        send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        lit("beq_odd", 32'h0020_8163, 1'b1, 3);
        send(3'd7, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd1, 32'd7);
        lit("fmt7", 32'h0000_0013, 1'b1, 0);

        // Backpressure with a pending bundle that must not be taken
        out_ready = 1'b0;
        set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            lit("hold", 32'h0000_0013, 1'b1, 0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        lit("release", 32'h0050_0093, 1'b0, 1);

        // Reset while a word is held
        out_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_addr", 32'(out_addr), 32'd3);
        chk("midrst_err_seen", 32'(err_seen), 32'd0);
        out_ready = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            r = $urandom;
            in_fmt = r[2:0]; in_rd = r[7:3]; in_rs1 = r[12:8]; in_rs2 = r[17:13];
            in_funct3 = r[20:18]; in_funct7 = r[27:21];
            r = $urandom;
            in_opcode = r[6:0];
            case ($urandom_range(0, 5))
                0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
                2: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
                3: imm = $urandom & 32'hFFFF_F000;
                4: imm = BND[$urandom_range(0, 18)];
                default: imm = $urandom;
            endcase
            in_imm = imm;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RV32I instruction encoder: accepts decoded fields (format, opcode, registers, functs, signed immediate) over a valid/ready handshake, packs them into a 32-bit instruction word with the immediate scattered per format, range-checks the immediate, and emits the word with a sequential word address. It is the packing counterpart to the immediate generator. It sits between the test/boot-loader front end and instruction-memory write port, so the core can be loaded with programs built from field descriptions.

## Interface
- `ADDR_WIDTH`, default 10: width of the word-address counter.
- `BASE_ADDR`, default 0: first word address emitted after reset. Must fit in `ADDR_WIDTH`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder can accept a bundle this cycle.
- `in_fmt` input 3: format code, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `in_opcode` input 7: opcode, placed in bits [6:0] unchanged.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_funct3` input 3, `in_funct7` input 7: function fields.
- `in_imm` input 32: immediate as a signed byte offset or value. For U format it is the full upper value, with bits [11:0] expected to be zero.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_instr` output 32: encoded instruction.
- `out_addr` output ADDR_WIDTH: word address of `out_instr`.
- `out_err` output 1: immediate or format error for this word.
- `err_seen` output 1: sticky OR of every emitted `out_err`.

## Operation
Packing uses `imm` = `in_imm`. Fields are listed MSB to LSB:
- R: funct7, rs2, rs1, funct3, rd, opcode.
- I: imm[11:0], rs1, funct3, rd, opcode.
- S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
- B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
- U: imm[31:12], rd, opcode.
- J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Unused fields are ignored.

Error rules (`out_err`=1):
- I and S: the immediate is not in [-2048, 2047].
- B: the immediate is not in [-4096, 4094], or imm[0]=1.
- J: the immediate is not in [-1048576, 1048574], or imm[0]=1.
- U: imm[11:0]≠0.
- Illegal `in_fmt`: `out_instr` = 0x00000013 (NOP).
- For range errors the word is still packed from truncated bits and emitted.
- R format never errors.

Address and flags:
- `out_addr` starts at `BASE_ADDR`.
- It increments by 1 after each output transfer (`out_valid && out_ready`), including error words.
- It wraps modulo 2^ADDR_WIDTH.
- `err_seen` sets on any output transfer with `out_err`=1 and clears only on `rst`.

## Timing
- Single output register stage. `in_ready = !out_valid || out_ready` (combinational from `out_ready`).
- An input transfer (`in_valid && in_ready`) at edge N puts the encoded word on the outputs after edge N, so `out_valid`=1 in cycle N+1. Latency is 1 cycle.
- Simultaneous output and input transfer: the register reloads with the new word, `out_valid` stays 1, and the address advances by 1. Full throughput is 1 word per cycle.
- `out_valid`=1 with `out_ready`=0: `out_instr`, `out_addr` and `out_err` hold stable and `in_ready`=0.
- `out_valid` does not depend on `out_ready`. It drops only after a transfer with no new input.
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, `err_seen`=0, `out_addr`=`BASE_ADDR`.
- Reset mid-stream discards any held word without a transfer.

## Structure
- Shared package `instr_pkg`:
  - `instr_fmt_e` enum (FMT_R..FMT_J).
  - Opcode constants (OP_IMM=7'b0010011, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM).
  - `NOP_INSTR`=32'h00000013.
  - Immediate range constants.
- Sub-module `instr_pack`: combinational packing plus error check (fields in → word, err out).
- The top holds the output register, handshake, address counter and sticky flag.
- Bench closes the loop: `out_instr` fed to the immediate generator must return the original `in_imm` whenever `out_err`=0.

## Test plan
- I: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 → `out_instr`=0x00500093, `out_addr`=BASE, `out_err`=0, one cycle after the transfer.
- Back-to-back with `out_ready`=1:
  - S sw (funct3=2, rs1=1, rs2=2, imm=8) → 0x0020A423.
  - B beq (rs1=1, rs2=2, imm=-4) → 0xFE208EE3.
  - J jal (rd=1, imm=8) → 0x008000EF.
  - Addresses BASE+0, +1, +2, one word per cycle.
- U lui (rd=5, imm=0x12345000) → 0x123452B7. Then U with imm=0x12345001 → `out_err`=1 and `err_seen`=1, and it stays 1 for later clean words.
- I with imm=2048 → `out_err`=1, `out_instr`=0x80000093. B with imm=3 → `out_err`=1. `in_fmt`=7 → 0x00000013 with `out_err`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles with `out_valid`=1 → outputs stable, `in_ready`=0, no address advance. Release → the next word carries the next address.
- ADDR_WIDTH=2, BASE_ADDR=3 → addresses 3, 0, 1, 2, 3. Assert `rst` while a word is held → `out_valid`=0, `out_addr`=3, `err_seen`=0.
